// File: rtl/cd_cfg_pkg.sv
// Shared types and defaults for the clock-divider configuration sequencer.
package cd_cfg_pkg;

  typedef enum logic [2:0] {
    ST_BOOT_VGA,
    ST_BOOT_UART,
    ST_IDLE,
    ST_ISSUE,
    ST_COMPLETE
  } cd_cfg_state_t;

  localparam int CD_ADDR_VGA_DEF  = 0;
  localparam int CD_ADDR_UART_DEF = 1;
  localparam int CD_TIMEOUT_DEF   = 1024;

  // Width of a counter that must hold 0 .. timeout-1.
  function automatic int cd_cnt_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

  localparam int CD_TIMEOUT_CNT_W = cd_cnt_width(CD_TIMEOUT_DEF);

endpackage

// File: rtl/cd_cfg_rr_arb.sv
// Combinational round-robin picker: first valid requester at or above ptr, with wrap.
module cd_cfg_rr_arb #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  // Scan offsets 0..N_REQ-1 from ptr; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!grant_any && req_valid[j] &&
            ((int'(ptr) + i == j) || (int'(ptr) + i == j + N_REQ))) begin
          grant_any = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/cd_cfg_sequencer.sv
// Clock-divider config controller: boot defaults, then round-robin runtime writes
// with timeout and shadow copies of the last accepted limits.
module cd_cfg_sequencer
  import cd_cfg_pkg::*;
#(
  parameter int                           WIDTH_CONFIG_ADDR = 4,
  parameter int                           WIDTH_CONFIG_DATA = 16,
  parameter int                           N_REQ             = 2,
  parameter logic [WIDTH_CONFIG_ADDR-1:0] ADDR_VGA          = WIDTH_CONFIG_ADDR'(CD_ADDR_VGA_DEF),
  parameter logic [WIDTH_CONFIG_ADDR-1:0] ADDR_UART         = WIDTH_CONFIG_ADDR'(CD_ADDR_UART_DEF),
  parameter logic [WIDTH_CONFIG_DATA-1:0] DEFAULT_RES       = WIDTH_CONFIG_DATA'(1),
  parameter logic [WIDTH_CONFIG_DATA-1:0] DEFAULT_BAUD      = WIDTH_CONFIG_DATA'(434),
  parameter int                           TIMEOUT           = CD_TIMEOUT_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ*WIDTH_CONFIG_ADDR-1:0]   req_addr,
  input  logic [N_REQ*WIDTH_CONFIG_DATA-1:0]   req_data,
  output logic [N_REQ-1:0]                     req_ready,
  output logic [N_REQ-1:0]                     req_done,
  output logic                                 req_err,
  output logic [WIDTH_CONFIG_ADDR-1:0]         c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0]         c_data,
  output logic                                 c_valid,
  input  logic                                 c_ready,
  output logic                                 boot_done,
  output logic                                 boot_err,
  output logic [WIDTH_CONFIG_DATA-1:0]         cur_res,
  output logic [WIDTH_CONFIG_DATA-1:0]         cur_baud
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cd_cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  cd_cfg_state_t               state;
  logic [IDX_W-1:0]            ptr;
  logic [CNT_W-1:0]            cnt;
  logic [N_REQ-1:0]            win;        // one-hot owner of the write in flight
  logic [IDX_W-1:0]            win_idx;
  logic                        int_src;    // write in flight is a boot write
  logic                        boot_uart;  // boot write in flight is the UART one
  logic                        cmp_wait;   // illegal address: hold COMPLETE one cycle before done

  logic [N_REQ-1:0]             grant;
  logic [IDX_W-1:0]             grant_idx;
  logic                         grant_any;
  logic [WIDTH_CONFIG_ADDR-1:0] win_addr;
  logic [WIDTH_CONFIG_DATA-1:0] win_data;
  logic                         win_legal;
  logic                         xfer;

  cd_cfg_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Select the winner's address/data slice and classify the address.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant[j]) begin
        win_addr = req_addr[j*WIDTH_CONFIG_ADDR +: WIDTH_CONFIG_ADDR];
        win_data = req_data[j*WIDTH_CONFIG_DATA +: WIDTH_CONFIG_DATA];
      end
    end
    win_legal = (win_addr == ADDR_VGA) || (win_addr == ADDR_UART);
    xfer      = c_valid && c_ready;
  end

  // Sequencer FSM with registered outputs, shadow registers and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_BOOT_VGA;
      ptr       <= '0;
      cnt       <= '0;
      win       <= '0;
      win_idx   <= '0;
      int_src   <= 1'b0;
      boot_uart <= 1'b0;
      cmp_wait  <= 1'b0;
      req_ready <= '0;
      req_done  <= '0;
      req_err   <= 1'b0;
      c_addr    <= '0;
      c_data    <= '0;
      c_valid   <= 1'b0;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
      cur_res   <= '0;
      cur_baud  <= '0;
    end else begin
      req_ready <= '0;
      req_done  <= '0;
      req_err   <= 1'b0;
      case (state)
        ST_BOOT_VGA: begin
          c_addr    <= ADDR_VGA;
          c_data    <= DEFAULT_RES;
          c_valid   <= 1'b1;
          int_src   <= 1'b1;
          boot_uart <= 1'b0;
          cnt       <= '0;
          state     <= ST_ISSUE;
        end
        ST_BOOT_UART: begin
          c_addr    <= ADDR_UART;
          c_data    <= DEFAULT_BAUD;
          c_valid   <= 1'b1;
          int_src   <= 1'b1;
          boot_uart <= 1'b1;
          cnt       <= '0;
          state     <= ST_ISSUE;
        end
        ST_IDLE: begin
          if (grant_any) begin
            win       <= grant;
            win_idx   <= grant_idx;
            c_addr    <= win_addr;
            c_data    <= win_data;
            req_ready <= grant;
            int_src   <= 1'b0;
            cnt       <= '0;
            if (win_legal) begin
              c_valid <= 1'b1;
              state   <= ST_ISSUE;
            end else begin
              cmp_wait <= 1'b1;
              state    <= ST_COMPLETE;
            end
          end
        end
        ST_ISSUE: begin
          if (xfer) begin
            c_valid <= 1'b0;
            state   <= ST_COMPLETE;
            if (c_addr == ADDR_VGA) begin
              cur_res <= c_data;
            end else if (c_addr == ADDR_UART) begin
              cur_baud <= c_data;
            end
            if (!int_src) begin
              req_done <= win;
            end
          end else if (cnt == CNT_LAST) begin
            c_valid <= 1'b0;
            state   <= ST_COMPLETE;
            if (int_src) begin
              boot_err <= 1'b1;
            end else begin
              req_done <= win;
              req_err  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_COMPLETE: begin
          if (cmp_wait) begin
            cmp_wait <= 1'b0;
            req_done <= win;
            req_err  <= 1'b1;
          end else if (int_src) begin
            if (boot_uart) begin
              boot_done <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              state <= ST_BOOT_UART;
            end
          end else begin
            ptr   <= (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_BOOT_VGA;
      endcase
    end
  end

endmodule

// File: doc/cd_cfg_sequencer.md
# cd_cfg_sequencer

Configuration controller for the clock divider's config port. After reset it writes the default VGA resolution limit and UART baudrate limit. It then round-robin arbitrates runtime configuration writes from N_REQ requesters (UART command decoder, switch panel, ...) onto the single c_addr/c_data/c_valid/c_ready port. It also tracks the last accepted value of each limit and times out writes that are never accepted.

## Interface
- WIDTH_CONFIG_ADDR, 4, config address width
- WIDTH_CONFIG_DATA, 16, config data width
- N_REQ, 2, number of runtime requesters (2..8)
- ADDR_VGA, 0, config address of the VGA resolution limit
- ADDR_UART, 1, config address of the UART baudrate limit
- DEFAULT_RES, 1, boot value written to ADDR_VGA
- DEFAULT_BAUD, 434, boot value written to ADDR_UART
- TIMEOUT, 1024, max ISSUE cycles before a write is abandoned (>=2)

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  per-requester write request, held until req_ready
- req_addr  in  N_REQ*WIDTH_CONFIG_ADDR  flattened; slice i belongs to requester i
- req_data  in  N_REQ*WIDTH_CONFIG_DATA  flattened; slice i belongs to requester i
- req_ready  out  N_REQ  one-cycle acceptance pulse, one-hot
- req_done  out  N_REQ  one-cycle completion pulse, one-hot
- req_err  out  1  qualifies req_done: 1 = timeout or illegal address
- c_addr  out  WIDTH_CONFIG_ADDR  to clock divider
- c_data  out  WIDTH_CONFIG_DATA  to clock divider
- c_valid  out  1  to clock divider
- c_ready  in  1  from clock divider
- boot_done  out  1  high once both boot writes have finished; sticky until rst
- boot_err  out  1  sticky; a boot write timed out
- cur_res  out  WIDTH_CONFIG_DATA  last accepted VGA limit
- cur_baud  out  WIDTH_CONFIG_DATA  last accepted UART limit

## Operation
- States: BOOT_VGA, BOOT_UART, IDLE, ISSUE, COMPLETE.
- Reset behaviour:
  - While rst=1, all outputs are 0, the state is BOOT_VGA, the round-robin pointer is 0 and the timeout counter is 0.
  - Reset asserted mid-transaction abandons the transaction. No req_done is issued for it.
- BOOT_VGA and BOOT_UART:
  - Each loads {ADDR_VGA, DEFAULT_RES} or {ADDR_UART, DEFAULT_BAUD} and runs the same ISSUE/COMPLETE path as a runtime write, with an internal source.
  - The internal source never pulses req_ready or req_done.
  - Order is VGA first, then UART.
  - After the UART write completes, boot_done=1 and the state goes to IDLE.
  - If a boot write times out, boot_err=1 and boot still proceeds.
- IDLE (only reachable after boot; requests during boot wait):
  - The winner is the first requester with req_valid=1, searching from the pointer upward with wrap-around.
  - The winner's addr/data are latched.
  - If the latched addr is neither ADDR_VGA nor ADDR_UART, go to COMPLETE with err=1 and skip ISSUE.
  - Otherwise go to ISSUE.
- ISSUE:
  - c_valid=1 with the latched addr/data, held stable.
  - A transfer occurs on a clock edge where c_valid && c_ready. Go to COMPLETE with err=0 and update cur_res or cur_baud.
  - The counter increments every cycle without a transfer. When it reaches TIMEOUT-1 with no transfer, go to COMPLETE with err=1; c_valid drops.
- COMPLETE:
  - req_done[winner]=1 and req_err=err for this cycle.
  - Pointer = (winner+1) mod N_REQ. This also applies on error.
  - Go to IDLE.
- The shadow registers cur_res and cur_baud change only on a successful transfer.

## Timing
- Request sampled in IDLE in cycle t:
  - req_ready[winner] pulses in cycle t+1. It is registered and coincides with the first ISSUE cycle.
  - The requester may drop req_valid or change its addr/data from t+2 onward.
- c_valid rises in t+1. If c_ready=1 in t+1, req_done pulses in t+2 and the block is back in IDLE in t+3. Minimum 3 cycles per write.
- Illegal address: req_ready at t+1, req_done with err at t+2, c_valid never asserted.
- Timeout: c_valid is high for exactly TIMEOUT cycles, then req_done with err in the following cycle.
- c_ready while c_valid=0 is ignored.
- Boot: c_valid first rises in the first cycle after rst deasserts. boot_done rises in the cycle after the second COMPLETE.

## Structure
- Shared package cd_cfg_pkg holds:
  - the state enum;
  - the ADDR_VGA and ADDR_UART defaults;
  - a localparam TIMEOUT counter width = clog2(TIMEOUT).
- Sub-module cd_cfg_rr_arb is a combinational round-robin priority picker. Inputs: req_valid, pointer. Outputs: one-hot grant and grant index.
- All state, latches and counters live in the top.

## Test plan
- Boot with c_ready tied 1:
  - c_valid pulses {0,1} then {1,434}.
  - boot_done=1 after the second write completes.
  - cur_res=1, cur_baud=434, no req_done.
- Both requesters assert simultaneously in IDLE with pointer=0 (req0 {1,868}, req1 {0,2}):
  - req0 is served first, then req1.
  - Final cur_baud=868 and cur_res=2.
  - req_ready and req_done stay one-hot.
- Requester 1 holds req_valid continuously while requester 0 fires repeatedly: grants alternate 0,1,0,1.
- req0 writes addr 5: req_ready then req_done with req_err=1, c_valid never high, shadows unchanged.
- c_ready stuck 0 on a runtime write:
  - c_valid is high exactly 1024 cycles, then req_done with err=1.
  - cur_* unchanged; the next request is served normally.
- rst asserted during ISSUE of a runtime write:
  - c_valid=0 and no req_done in the reset cycles.
  - After release, boot reruns from BOOT_VGA.
